// File: rtl/pixel_write_coalescer.sv
// Halfword pixel write coalescer: merges 16-bit writes to the same 32-bit word
// into one pending entry, then queues merged words for a 32-bit Avalon-MM master.
module pixel_write_coalescer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          in_address,
    input  logic [15:0]                in_writedata,
    input  logic                       in_write,
    output logic                       in_waitrequest,
    output logic [ADDR_W-1:0]          m_address,
    output logic [31:0]                m_writedata,
    output logic [3:0]                 m_byteenable,
    output logic                       m_write,
    input  logic                       m_waitrequest,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       idle,
    output logic                       error
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = ADDR_W - 2;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WW-1:0]  pend_word_q, pend_word_d;
    logic [31:0]    pend_data_q, pend_data_d;
    logic [3:0]     pend_be_q, pend_be_d;
    logic           pend_valid_q, pend_valid_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [LW-1:0]  level_q, level_d;
    logic           error_q, error_d;

    logic [WW-1:0]  mem_word_q [DEPTH];
    logic [31:0]    mem_data_q [DEPTH];
    logic [3:0]     mem_be_q   [DEPTH];

    logic [WW-1:0]  in_word;
    logic [31:0]    lane_data;
    logic [31:0]    keep_mask;
    logic [3:0]     lane_be;
    logic           mergeable;
    logic           full;
    logic           accept;
    logic           push;
    logic           pop;

    assign in_word   = in_address[ADDR_W-1:2];
    assign lane_data = in_address[1] ? {in_writedata, 16'h0000} : {16'h0000, in_writedata};
    assign keep_mask = in_address[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
    assign lane_be   = in_address[1] ? 4'b1100 : 4'b0011;
    assign mergeable = pend_valid_q && (in_word == pend_word_q);
    assign full      = (level_q == FULL_LEVEL);

    // Stall only when the pending entry must move into a FIFO that is already full.
    assign in_waitrequest = reset || (pend_valid_q && full && !mergeable);
    assign accept         = in_write && !in_waitrequest;
    assign pop            = m_write && !m_waitrequest;

    always_comb begin
        pend_word_d  = pend_word_q;
        pend_data_d  = pend_data_q;
        pend_be_d    = pend_be_q;
        pend_valid_d = pend_valid_q;
        error_d      = error_q;
        push         = 1'b0;
        if (accept && in_address[0]) begin
            error_d = 1'b1;
        end else if (accept) begin
            if (mergeable) begin
                pend_data_d = (pend_data_q & keep_mask) | lane_data;
                pend_be_d   = pend_be_q | lane_be;
            end else begin
                push         = pend_valid_q;
                pend_word_d  = in_word;
                pend_data_d  = lane_data;
                pend_be_d    = lane_be;
                pend_valid_d = 1'b1;
            end
        end else if (!in_write && pend_valid_q && !full) begin
            push         = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        level_d = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_word_q  <= '0;
            pend_data_q  <= '0;
            pend_be_q    <= '0;
            pend_valid_q <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            level_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            pend_word_q  <= pend_word_d;
            pend_data_q  <= pend_data_d;
            pend_be_q    <= pend_be_d;
            pend_valid_q <= pend_valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            level_q      <= level_d;
            error_q      <= error_d;
        end
    end

    // Storage needs no reset; only entries between head and tail are ever observed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_word_q[tail_q] <= pend_word_q;
            mem_data_q[tail_q] <= pend_data_q;
            mem_be_q[tail_q]   <= pend_be_q;
        end
    end

    assign m_write      = (level_q != '0);
    assign m_address    = m_write ? {mem_word_q[head_q], 2'b00} : '0;
    assign m_writedata  = m_write ? mem_data_q[head_q] : '0;
    assign m_byteenable = m_write ? mem_be_q[head_q] : '0;
    assign level        = level_q;
    assign idle         = !pend_valid_q && (level_q == '0);
    assign error        = error_q;

endmodule

// File: tb/tb_pixel_write_coalescer.sv
// Self-checking bench for pixel_write_coalescer: expected master writes are queued
// as stimulus is driven and compared as the fabric accepts them.
module tb_pixel_write_coalescer;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } expWrite_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inAddress = '0;
   logic [15:0] inWritedata = '0;
   logic        inWrite = 1'b0;
   logic        inWaitrequest;
   logic [31:0] mAddress;
   logic [31:0] mWritedata;
   logic [3:0]  mByteenable;
   logic        mWrite;
   logic        mWaitrequest = 1'b0;
   logic [3:0]  level;
   logic        idle;
   logic        error;

   expWrite_t   scoreboard[$];
   int          checkCount = 0;
   int          failCount = 0;
   int          writeCount = 0;
   int          countBefore;

   logic        heldValid = 1'b0;
   logic [31:0] heldAddr;
   logic [31:0] heldData;
   logic [3:0]  heldBe;

   pixel_write_coalescer #(.DEPTH(8), .ADDR_W(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_address     (inAddress),
      .in_writedata   (inWritedata),
      .in_write       (inWrite),
      .in_waitrequest (inWaitrequest),
      .m_address      (mAddress),
      .m_writedata    (mWritedata),
      .m_byteenable   (mByteenable),
      .m_write        (mWrite),
      .m_waitrequest  (mWaitrequest),
      .level          (level),
      .idle           (idle),
      .error          (error)
   );

   always #5 clock = ~clock;

   // Every comparison in the bench funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      expWrite_t e;
      e.addr = addr;
      e.data = data;
      e.be   = be;
      scoreboard.push_back(e);
   endtask

   // Presents one halfword write and returns just after the edge that accepted it.
   task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] data);
      int budget;
      inAddress   = addr;
      inWritedata = data;
      inWrite     = 1'b1;
      budget      = 0;
      @(negedge clock);
      while (inWaitrequest && budget < 200) begin
         @(negedge clock);
         budget++;
      end
      if (inWaitrequest) checkOutput("accept_timeout", {31'b0, inWaitrequest}, 32'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic waitDrain(input string tag);
      int budget;
      budget = 0;
      while (!(idle && scoreboard.size() == 0) && budget < 200) begin
         @(negedge clock);
         budget++;
      end
      checkOutput(tag, {31'b0, idle}, 32'd1);
   endtask

   // Fabric-side monitor: scores every accepted master write and checks stall stability.
   always @(negedge clock) begin
      if (reset) begin
         heldValid <= 1'b0;
      end else begin
         if (heldValid && mWrite) begin
            checkOutput("stall_addr", mAddress, heldAddr);
            checkOutput("stall_data", mWritedata, heldData);
            checkOutput("stall_be", {28'b0, mByteenable}, {28'b0, heldBe});
         end
         if (mWrite && !mWaitrequest) begin
            writeCount++;
            if (scoreboard.size() == 0) begin
               checkOutput("unexpected_write", mAddress, 32'd0);
            end else begin
               expWrite_t e;
               e = scoreboard.pop_front();
               checkOutput("m_address", mAddress, e.addr);
               checkOutput("m_writedata", mWritedata, e.data);
               checkOutput("m_byteenable", {28'b0, mByteenable}, {28'b0, e.be});
            end
         end
         heldValid <= mWrite && mWaitrequest;
         heldAddr  <= mAddress;
         heldData  <= mWritedata;
         heldBe    <= mByteenable;
      end
   end

   initial begin
      #1;
      checkOutput("rst_m_write", {31'b0, mWrite}, 32'd0);
      checkOutput("rst_level", {28'b0, level}, 32'd0);
      checkOutput("rst_idle", {31'b0, idle}, 32'd1);
      checkOutput("rst_error", {31'b0, error}, 32'd0);
      checkOutput("rst_waitreq", {31'b0, inWaitrequest}, 32'd1);
      checkOutput("rst_m_address", mAddress, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] adjacent merge");
      countBefore = writeCount;
      expectWrite(32'h0800_0000, 32'hBBBB_AAAA, 4'b1111);
      applyStimulus(32'h0800_0000, 16'hAAAA);
      applyStimulus(32'h0800_0002, 16'hBBBB);
      inWrite = 1'b0;
      waitDrain("merge_drain");
      checkOutput("merge_count", writeCount - countBefore, 32'd1);

      $display("[TB] lone upper half");
      expectWrite(32'h0800_0004, 32'h1234_0000, 4'b1100);
      applyStimulus(32'h0800_0006, 16'h1234);
      inWrite = 1'b0;
      @(negedge clock);
      checkOutput("lone_m_write_early", {31'b0, mWrite}, 32'd0);
      @(negedge clock);
      checkOutput("lone_m_write", {31'b0, mWrite}, 32'd1);
      checkOutput("lone_addr", mAddress, 32'h0800_0004);
      @(negedge clock);
      checkOutput("lone_idle", {31'b0, idle}, 32'd1);

      $display("[TB] same-half overwrite");
      countBefore = writeCount;
      expectWrite(32'h0800_0000, 32'h0000_2222, 4'b0011);
      applyStimulus(32'h0800_0000, 16'h1111);
      applyStimulus(32'h0800_0000, 16'h2222);
      inWrite = 1'b0;
      waitDrain("overwrite_drain");
      checkOutput("overwrite_count", writeCount - countBefore, 32'd1);

      $display("[TB] backpressure and full");
      mWaitrequest = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a;
         logic [15:0] d;
         a = 32'h0800_0100 + 32'(i * 4) + ((i % 2 == 1) ? 32'd2 : 32'd0);
         d = 16'hA000 + 16'(i);
         if (i % 2 == 1) expectWrite(32'h0800_0100 + 32'(i * 4), {d, 16'h0000}, 4'b1100);
         else            expectWrite(32'h0800_0100 + 32'(i * 4), {16'h0000, d}, 4'b0011);
         if (i < 9) begin
            applyStimulus(a, d);
         end else begin
            inAddress   = a;
            inWritedata = d;
            inWrite     = 1'b1;
            repeat (3) @(negedge clock);
            checkOutput("full_level", {28'b0, level}, 32'd8);
            checkOutput("full_waitreq", {31'b0, inWaitrequest}, 32'd1);
            @(posedge clock);
            #1 mWaitrequest = 1'b0;
            applyStimulus(a, d);
         end
      end
      inWrite = 1'b0;
      waitDrain("full_drain");

      $display("[TB] misaligned");
      countBefore = writeCount;
      applyStimulus(32'h0800_0001, 16'hFFFF);
      inWrite = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("mis_error", {31'b0, error}, 32'd1);
      checkOutput("mis_level", {28'b0, level}, 32'd0);
      checkOutput("mis_idle", {31'b0, idle}, 32'd1);
      checkOutput("mis_count", writeCount - countBefore, 32'd0);
      @(posedge clock);
      #1;
      expectWrite(32'h0800_0010, 32'h0000_5555, 4'b0011);
      applyStimulus(32'h0800_0010, 16'h5555);
      inWrite = 1'b0;
      waitDrain("mis_follow_drain");

      $display("[TB] reset mid-operation");
      mWaitrequest = 1'b1;
      applyStimulus(32'h0800_0200, 16'h0001);
      applyStimulus(32'h0800_0204, 16'h0002);
      applyStimulus(32'h0800_0208, 16'h0003);
      inWrite = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("pre_rst_level", {28'b0, level}, 32'd3);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_m_write", {31'b0, mWrite}, 32'd0);
      checkOutput("async_level", {28'b0, level}, 32'd0);
      checkOutput("async_idle", {31'b0, idle}, 32'd1);
      checkOutput("async_error", {31'b0, error}, 32'd0);
      scoreboard.delete();
      countBefore = writeCount;
      @(posedge clock);
      #3 reset = 1'b0;
      mWaitrequest = 1'b0;
      repeat (6) @(negedge clock);
      checkOutput("post_rst_count", writeCount - countBefore, 32'd0);
      checkOutput("post_rst_idle", {31'b0, idle}, 32'd1);

      checkOutput("scoreboard_empty", scoreboard.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/pixel_write_coalescer.md
Name: pixel_write_coalescer

Overview:
- Sits between the voxel_gpu m1 pixel-write master and the on-chip framebuffer RAM.
- Accepts 16-bit halfword pixel writes on an Avalon-MM slave interface with waitrequest.
- Merges adjacent halfwords that fall in the same 32-bit word into one write, buffers merged words in a FIFO, and drains them on a 32-bit Avalon-MM master with byteenable.
- Decouples shader pixel output from fabric stalls and halves write traffic for consecutive pixels.

Parameters:
- DEPTH, 8: number of FIFO entries; power of two, at least 2.
- ADDR_W, 32: byte-address width on both interfaces.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_address  in  ADDR_W  byte address of the halfword pixel; bit 0 must be 0.
- in_writedata  in  16  pixel data.
- in_write  in  1  write request from voxel_gpu m1.
- in_waitrequest  out  1  stall to voxel_gpu m1.
- m_address  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- m_writedata  out  32  merged word.
- m_byteenable  out  4  lane enables.
- m_write  out  1  master write request.
- m_waitrequest  in  1  fabric stall.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.
- idle  out  1  high when no pending entry and the FIFO is empty.
- error  out  1  sticky misaligned-write flag.

Behaviour:
- Reset is asynchronous and active-high.
  - Clears the pending register, the FIFO pointers, level and error immediately.
  - Reset values: m_write=0, level=0, idle=1, error=0, in_waitrequest=1 while reset is high.
  - m_address, m_writedata and m_byteenable are 0 while the FIFO is empty.
- Pending register: one entry holding {word=addr[ADDR_W-1:2], data32, be4}.
- Lane mapping:
  - addr[1]=0 → data goes to [15:0], be 0011.
  - addr[1]=1 → data goes to [31:16], be 1100.
  - Unenabled lanes hold 0.
- A write is accepted on a clock edge where in_write=1 and in_waitrequest=0.
  - in_waitrequest is combinational: pending_valid && level==DEPTH && !mergeable.
  - mergeable = pending_valid && in_address word == pending word.
  - Full status does not account for a same-cycle pop, so there is no bypass path from m_waitrequest to in_waitrequest.
- Accepted write, by case:
  - Misaligned (addr[0]=1): dropped, error←1, no state change.
  - mergeable: lanes for addr[1] overwrite pending data; be |= lane mask. If the same half is written twice, the last write wins.
  - Pending valid but not mergeable: pending is pushed into the FIFO and the new halfword becomes pending.
  - Pending empty: the new halfword becomes pending.
- Idle flush: on any edge with in_write=0, pending_valid=1 and level<DEPTH, pending is pushed and pending_valid←0.
- Latency: a lone halfword accepted at edge N is pushed at edge N+1; m_write is asserted in the cycle after edge N+1.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Output is driven combinationally from the head entry.
  - m_write = (level!=0).
  - m_address = {head.word, 2'b00}.
- Master handshake:
  - m_address, m_writedata and m_byteenable are held stable while m_write && m_waitrequest.
  - Pop occurs on an edge with m_write && !m_waitrequest.
  - Writes are issued strictly in acceptance order.
- Simultaneous push and pop in one edge: level is unchanged and both take effect.
- Push while level==DEPTH never occurs.
  - Non-mergeable input stalls via in_waitrequest.
  - Idle flush waits until level<DEPTH.
- idle = !pending_valid && level==0. It is usable by the driver before reading back the framebuffer.
- error is cleared only by reset.

Test Plan:
1. Adjacent merge: writes 0x08000000=0xAAAA then 0x08000002=0xBBBB on back-to-back cycles, m_waitrequest=0 → exactly one master write, address 0x08000000, data 0xBBBBAAAA, be 1111.
2. Lone upper half: write 0x08000006=0x1234, then in_write=0 → m_write rises 2 cycles after acceptance, address 0x08000004, data 0x12340000, be 1100; idle returns to 1 after the pop.
3. Same-half overwrite: 0x08000000=0x1111 then 0x08000000=0x2222 → one write, data 0x00002222, be 0011.
4. Backpressure and full, DEPTH=8: hold m_waitrequest=1 and issue writes to 10 distinct words.
   - The 9th write is accepted into pending.
   - The 10th write sees in_waitrequest=1 and stays stalled with level=8.
   - Release m_waitrequest → 10 master writes in order, each address stable throughout its stall, with wrap-around exercised.
5. Misaligned: write 0x08000001=0xFFFF → error=1, no master write, level=0, idle=1; a following aligned write proceeds normally.
6. Reset mid-operation: reset pulsed while level=3 and m_waitrequest=1 → m_write=0, level=0, idle=1 asynchronously, and no stale write appears after reset is released.
